// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx
// Purpose  : Serialises 12-bit DDFS samples into 16-bit MCP4921-style SPI
//            frames and pulses LDAC; single-entry pending buffer, latest wins.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_tx #(
    parameter int         CLK_DIV    = 4,
    parameter int         DATA_WIDTH = 12,
    parameter logic [3:0] CFG_BITS   = 4'b0011,
    parameter int         LDAC_PULSE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  dac_cs_n,
    output logic                  dac_sclk,
    output logic                  dac_mosi,
    output logic                  dac_ldac_n
);

    localparam int c_FRAME_W = DATA_WIDTH + 4;
    localparam int c_PH_W    = $clog2(CLK_DIV + 1);
    localparam int c_BIT_W   = $clog2(c_FRAME_W + 1);
    localparam int c_LD_W    = $clog2(LDAC_PULSE + 1);

    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME_W - 1);
    localparam logic [c_LD_W-1:0]  c_LD_LAST  = c_LD_W'(LDAC_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_LDAC  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [c_FRAME_W-1:0]    r_shreg;
    logic [DATA_WIDTH-1:0]   r_pend_data;
    logic                    r_pend_flag;
    logic [c_PH_W-1:0]       r_phase;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [c_LD_W-1:0]       r_ld_cnt;

    logic w_consume;
    logic w_phase_end;
    logic w_ldac_end;
    logic w_pend_next;
    logic w_active_next;

    always_comb begin
        w_consume     = (r_state == S_IDLE) && r_pend_flag;
        w_phase_end   = (r_phase == c_PH_LAST);
        w_ldac_end    = (r_state == S_LDAC) && (r_ld_cnt == c_LD_LAST);
        // A strobe on the consuming cycle refills the buffer without loss.
        w_pend_next   = sample_valid || (r_pend_flag && !w_consume);
        w_active_next = w_consume || ((r_state != S_IDLE) && !w_ldac_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_pend_data <= '0;
            r_pend_flag <= 1'b0;
            r_phase     <= '0;
            r_bit_cnt   <= '0;
            r_ld_cnt    <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            dac_cs_n    <= 1'b1;
            dac_sclk    <= 1'b0;
            dac_mosi    <= 1'b0;
            dac_ldac_n  <= 1'b1;
        end else begin
            r_pend_flag <= w_pend_next;
            busy        <= w_pend_next || w_active_next;
            if (sample_valid) begin
                r_pend_data <= sample;
            end
            if (sample_valid && r_pend_flag && !w_consume) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_consume) begin
                        r_shreg  <= {CFG_BITS, r_pend_data};
                        dac_mosi <= CFG_BITS[3];
                        dac_cs_n <= 1'b0;
                        r_phase  <= '0;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_phase_end) begin
                        r_phase   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else begin
                            // Data moves only on the falling edge, so it is stable at every rise.
                            dac_sclk <= 1'b0;
                            r_shreg  <= {r_shreg[c_FRAME_W-2:0], 1'b0};
                            if (r_bit_cnt == c_BIT_LAST) begin
                                dac_mosi <= 1'b0;
                                r_state  <= S_HOLD;
                            end else begin
                                dac_mosi  <= r_shreg[c_FRAME_W-2];
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_phase_end) begin
                        r_phase    <= '0;
                        r_ld_cnt   <= '0;
                        dac_cs_n   <= 1'b1;
                        dac_ldac_n <= 1'b0;
                        r_state    <= S_LDAC;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_LDAC: begin
                    if (w_ldac_end) begin
                        dac_ldac_n <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                    end
                end
                default: begin
                    dac_cs_n   <= 1'b1;
                    dac_sclk   <= 1'b0;
                    dac_ldac_n <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_tx
// Purpose  : Self-checking bench for dac_spi_tx (CLK_DIV=4 and CLK_DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_spi_tx;

    localparam int c_DIV_A = 4;
    localparam int c_DIV_B = 1;
    localparam int c_LDAC  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] smp [2];
    logic [1:0]  vld;
    logic [1:0]  busy, ovr, cs_n, sclk, mosi, ldac_n;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx #(.CLK_DIV(c_DIV_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sample(smp[0]), .sample_valid(vld[0]),
        .busy(busy[0]), .overrun(ovr[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
        .dac_mosi(mosi[0]), .dac_ldac_n(ldac_n[0])
    );

    dac_spi_tx #(.CLK_DIV(c_DIV_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sample(smp[1]), .sample_valid(vld[1]),
        .busy(busy[1]), .overrun(ovr[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
        .dac_mosi(mosi[1]), .dac_ldac_n(ldac_n[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    // Per-DUT monitor state
    int          low_cnt [2], rises [2], hi_run [2], ld_cnt [2];
    int          frames [2], ldacs [2], falls [2];
    int          cs_fall_cyc [2], ldac_rise_cyc [2], gap [2], t_drive [2];
    logic [15:0] fr [2];
    logic [1:0]  p_cs, p_sclk, p_ldac;

    function automatic int div(input int i);
        return (i == 0) ? c_DIV_A : c_DIV_B;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [15:0] f);
        if (i == 0) q0.push_back(f);
        else        q1.push_back(f);
    endtask

    task automatic frame_done(input int i);
        int          sz;
        logic [15:0] e;
        sz = (i == 0) ? q0.size() : q1.size();
        chk($sformatf("frame_expected[%0d]", i), 32'(sz != 0), 1);
        if (sz != 0) begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("frame_bits[%0d]", i), fr[i], e);
        end
        chk($sformatf("sclk_rises[%0d]", i), rises[i], 16);
        chk($sformatf("cs_low_cycles[%0d]", i), low_cnt[i], 34 * div(i));
        chk($sformatf("ldac_at_cs_rise[%0d]", i), ldac_n[i], 0);
        frames[i]++;
    endtask

    task automatic mon_step(input int i);
        if (!rst_n) begin
            p_cs[i] = 1'b1; p_sclk[i] = 1'b0; p_ldac[i] = 1'b1;
            ld_cnt[i] = 0; hi_run[i] = 0;
        end else begin
            if (!cs_n[i]) begin
                if (p_cs[i]) begin
                    falls[i]++;
                    gap[i] = cyc - ldac_rise_cyc[i];
                    cs_fall_cyc[i] = cyc;
                    low_cnt[i] = 0; rises[i] = 0; fr[i] = '0;
                end
                low_cnt[i]++;
                if (sclk[i] && !p_sclk[i]) begin
                    fr[i] = {fr[i][14:0], mosi[i]};
                    rises[i]++;
                end
            end else if (!p_cs[i]) begin
                frame_done(i);
            end
            if (sclk[i]) begin
                hi_run[i]++;
            end else if (p_sclk[i]) begin
                chk($sformatf("sclk_high_width[%0d]", i), hi_run[i], div(i));
                hi_run[i] = 0;
            end
            if (!ldac_n[i]) begin
                ld_cnt[i]++;
                chk($sformatf("cs_high_in_ldac[%0d]", i), cs_n[i], 1);
            end else if (!p_ldac[i]) begin
                chk($sformatf("ldac_width[%0d]", i), ld_cnt[i], c_LDAC);
                ld_cnt[i] = 0;
                ldac_rise_cyc[i] = cyc;
                ldacs[i]++;
            end
            p_cs[i] = cs_n[i]; p_sclk[i] = sclk[i]; p_ldac[i] = ldac_n[i];
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    endtask

    task automatic pulse(input int i, input logic [11:0] s, input logic [15:0] f, input bit do_push);
        @(negedge clk);
        smp[i] = s; vld[i] = 1'b1; t_drive[i] = cyc;
        if (do_push) push(i, f);
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    task automatic wait_ldac(input int i, input int target);
        int k = 0;
        while (ldacs[i] < target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("frame_done_in_time[%0d]", i), 32'(ldacs[i] >= target), 1);
    endtask

    typedef struct {
        int          dut;
        logic [11:0] s;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, f0, k;
        vec_t v;

        vecs[0] = '{0, 12'hA5C, 16'h3A5C};
        vecs[1] = '{0, 12'h000, 16'h3000};
        vecs[2] = '{0, 12'hFFF, 16'h3FFF};
        vecs[3] = '{0, 12'h555, 16'h3555};
        vecs[4] = '{1, 12'hFFF, 16'h3FFF};
        vecs[5] = '{1, 12'h000, 16'h3000};
        vecs[6] = '{1, 12'h800, 16'h3800};

        for (int i = 0; i < 2; i++) begin
            low_cnt[i] = 0; rises[i] = 0; hi_run[i] = 0; ld_cnt[i] = 0;
            frames[i] = 0; ldacs[i] = 0; falls[i] = 0; cs_fall_cyc[i] = 0;
            ldac_rise_cyc[i] = 0; gap[i] = 0; t_drive[i] = 0; fr[i] = '0;
            smp[i] = '0;
        end
        p_cs = '1; p_sclk = '0; p_ldac = '1;
        rst_n = 1'b0;
        vld   = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_cs_n[%0d]", i), cs_n[i], 1);
            chk($sformatf("rst_sclk[%0d]", i), sclk[i], 0);
            chk($sformatf("rst_mosi[%0d]", i), mosi[i], 0);
            chk($sformatf("rst_ldac_n[%0d]", i), ldac_n[i], 1);
            chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
            chk($sformatf("rst_overrun[%0d]", i), ovr[i], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-sample frames on both clock dividers
        for (int n = 0; n < 7; n++) begin
            v = vecs[n];
            base = ldacs[v.dut];
            pulse(v.dut, v.s, v.frame, 1'b1);
            wait_ldac(v.dut, base + 1);
            chk($sformatf("latency_vec%0d", n), cs_fall_cyc[v.dut] - t_drive[v.dut], 2);
            @(negedge clk);
            chk($sformatf("busy_after_vec%0d", n), busy[v.dut], 0);
            chk($sformatf("overrun_vec%0d", n), ovr[v.dut], 0);
        end

        // Second sample arrives mid-frame and follows back-to-back
        base = ldacs[0];
        pulse(0, 12'h123, 16'h3123, 1'b1);
        repeat (8) @(negedge clk);
        pulse(0, 12'h456, 16'h3456, 1'b1);
        wait_ldac(0, base + 2);
        chk("back_to_back_gap", gap[0], 1);
        chk("overrun_two_samples", ovr[0], 0);

        // Overwrite of a pending sample: 222 is lost
        base = ldacs[0];
        pulse(0, 12'h111, 16'h3111, 1'b1);
        repeat (20) @(negedge clk);
        pulse(0, 12'h222, 16'h3222, 1'b0);
        repeat (20) @(negedge clk);
        pulse(0, 12'h333, 16'h3333, 1'b1);
        chk("overrun_set", ovr[0], 1);
        wait_ldac(0, base + 2);
        @(negedge clk);
        chk("overrun_sticky", ovr[0], 1);
        chk("busy_after_overrun", busy[0], 0);

        // Reset in the middle of bit 7 with a sample pending
        pulse(0, 12'h321, 16'h3321, 1'b1);
        repeat (5) @(negedge clk);
        pulse(0, 12'h654, 16'h3654, 1'b1);
        k = 0;
        while ((rises[0] != 8 || cs_n[0]) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_bit7", 32'(k < 1000), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", cs_n[0], 1);
        chk("midrst_sclk", sclk[0], 0);
        chk("midrst_ldac_n", ldac_n[0], 1);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_overrun", ovr[0], 0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        f0 = falls[0];
        repeat (300) @(negedge clk);
        chk("no_frame_after_reset", falls[0] - f0, 0);
        chk("idle_after_reset", busy[0], 0);

        // New sample on the exact cycle that consumes the pending one
        base = ldacs[0];
        pulse(0, 12'h555, 16'h3555, 1'b1);
        repeat (20) @(negedge clk);
        pulse(0, 12'h666, 16'h3666, 1'b1);
        k = 0;
        while (ldac_n[0] !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        while (ldac_n[0] !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("found_consume_cycle", 32'(k < 1000), 1);
        smp[0] = 12'h777; vld[0] = 1'b1;
        push(0, 16'h3777);
        @(negedge clk);
        vld[0] = 1'b0;
        wait_ldac(0, base + 3);
        chk("overrun_coincident", ovr[0], 0);

        repeat (5) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
